// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage.
// Owns the architectural PC and issues one word fetch at a time over a
// valid/ready request channel plus a response channel. It hands the
// instruction and its PC to decode, then waits for the next PC from execute.
// Only one instruction is in flight and there is no prediction.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        mem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        npc_valid,
  input  logic [31:0] npc,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    NPC
  } state_t;

  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  state_t      state;
  logic [31:0] pc;
  logic [15:0] tmo_cnt;

  assign mem_req_addr = pc;

  // Fetch sequencer. All outputs are registered. mem_req_valid is set on entry
  // to REQ from the alignment of the incoming PC, so a misaligned PC never
  // raises a request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      tmo_cnt       <= '0;
      mem_req_valid <= 1'b0;
      inst_valid    <= 1'b0;
      inst          <= '0;
      inst_pc       <= RESET_PC;
      inst_fault    <= 1'b0;
      fetch_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          state         <= REQ;
          mem_req_valid <= (pc[1:0] == 2'b00);
        end
        REQ: begin
          if (pc[1:0] != 2'b00) begin
            state      <= OUT;
            inst       <= '0;
            inst_fault <= 1'b1;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
          end else if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
            tmo_cnt       <= '0;
          end
        end
        WAIT: begin
          // A response that lands on the timeout cycle takes priority.
          if (mem_resp_valid) begin
            state      <= OUT;
            inst       <= mem_resp_err ? '0 : mem_resp_data;
            inst_fault <= mem_resp_err;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
          end else if (tmo_cnt + 16'd1 == TMO_LIMIT) begin
            state      <= OUT;
            inst       <= '0;
            inst_fault <= 1'b1;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        OUT: begin
          if (inst_ready) begin
            inst_valid <= 1'b0;
            fetch_cnt  <= fetch_cnt + 32'd1;
            if (npc_valid) begin
              pc            <= npc;
              state         <= REQ;
              mem_req_valid <= (npc[1:0] == 2'b00);
            end else begin
              state <= NPC;
            end
          end
        end
        NPC: begin
          if (npc_valid) begin
            pc            <= npc;
            state         <= REQ;
            mem_req_valid <= (npc[1:0] == 2'b00);
          end
        end
        default: begin
          state         <= IDLE;
          mem_req_valid <= 1'b0;
          inst_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: randomized bench for ifu_fetch.
// The bench plays the instruction memory and the decode/execute stages. A
// transaction-level model predicts each fetch outcome and its timing. Inputs
// are driven on the falling edge and outputs are sampled there too.
module tb_ifu_fetch;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          TMO      = 4;
  localparam int          N_ITER   = 1500;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid, mem_resp_err;
  logic [31:0] mem_resp_data;
  logic        inst_valid, inst_ready, inst_fault;
  logic [31:0] inst, inst_pc;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] fetch_cnt;

  ifu_fetch #(.RESET_PC(RESET_PC), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .npc_valid(npc_valid), .npc(npc), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model state: one fetch at a time
  logic [31:0] exp_addr, exp_inst, exp_cnt;
  logic        exp_fault;
  bit          awaiting, accepted, have_outcome, inst_seen, pending, outstanding;
  int          deliver_iter, accept_iter, exp_out_iter, lat, cd, npc_delay, stray, n_deliv;
  int          rst_hold;
  bit          did_rst;
  logic [31:0] sched_data;
  logic        sched_err;

  function automatic bit aligned(input logic [31:0] a);
    return a[1:0] == 2'b00;
  endfunction

  task automatic check_reset_values();
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, RESET_PC);
    check("rst_inst_fault", 32'(inst_fault), 32'd0);
    check("rst_fetch_cnt", fetch_cnt, 32'd0);
  endtask

  task automatic deliver(input logic [31:0] a, input int it);
    exp_addr     = a;
    deliver_iter = it;
    awaiting     = 1;
    accepted     = 0;
    inst_seen    = 0;
    n_deliv++;
    if (!aligned(a)) begin
      have_outcome = 1;
      exp_inst     = 32'd0;
      exp_fault    = 1'b1;
      exp_out_iter = it + 2;
    end else begin
      have_outcome = 0;
    end
  endtask

  function automatic logic [31:0] next_addr();
    logic [31:0] a;
    if (n_deliv == 1) return exp_addr + 32'd4;
    if (n_deliv == 2) return 32'h8000_0102;
    a = {16'h8000, 14'($urandom), 2'b00};
    if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  initial begin
    bit directed;
    reset          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    mem_resp_err   = 1'b0;
    inst_ready     = 1'b0;
    npc_valid      = 1'b0;
    npc            = '0;
    exp_cnt = 0; n_deliv = 0; pending = 0; outstanding = 0; stray = 0;
    rst_hold = 0; did_rst = 0; awaiting = 0;
    repeat (2) @(negedge clk);
    check_reset_values();
    reset = 1'b1;
    deliver(RESET_PC, 0);

    for (int it = 1; it <= N_ITER; it++) begin
      @(negedge clk);
      directed = (n_deliv <= 2);

      // Reset held low: outputs stay at reset values, responses are stray
      if (rst_hold > 0) begin
        check_reset_values();
        rst_hold--;
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
        if (rst_hold == 0) begin
          reset = 1'b1;
          stray = 1;
          deliver(RESET_PC, it);
        end
        continue;
      end

      // Reset asserted mid-fetch while the DUT waits for a response
      if (!did_rst && it >= 300 && accepted && awaiting && !inst_seen &&
          it > accept_iter && it < exp_out_iter) begin
        did_rst = 1;
        reset = 1'b0;
        #1;
        check_reset_values();
        exp_cnt = 0; outstanding = 0; pending = 0; awaiting = 0;
        inst_ready = 1'b1; npc_valid = 1'b0; mem_req_ready = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data  = $urandom;
        rst_hold = 2;
        continue;
      end

      // ---------- observe ----------
      check("fetch_cnt", fetch_cnt, exp_cnt);
      if (awaiting && it == deliver_iter + 1)
        check("req_start", 32'(mem_req_valid), 32'(aligned(exp_addr)));
      if (mem_req_valid) begin
        check("req_legal", 32'(awaiting && !accepted && aligned(exp_addr)), 32'd1);
        check("req_addr", mem_req_addr, exp_addr);
      end
      if (awaiting && have_outcome && !inst_seen && it == exp_out_iter)
        check("inst_rise", 32'(inst_valid), 32'd1);
      if (inst_valid) begin
        check("inst_legal", 32'(awaiting && have_outcome), 32'd1);
        if (awaiting && have_outcome) begin
          if (!inst_seen) begin
            inst_seen = 1;
            check("inst_lat", 32'(it), 32'(exp_out_iter));
          end
          check("inst", inst, exp_inst);
          check("inst_pc", inst_pc, exp_addr);
          check("inst_fault", 32'(inst_fault), 32'(exp_fault));
        end
      end else if (awaiting && inst_seen) begin
        check("inst_hold", 32'(inst_valid), 32'd1);
      end

      // ---------- memory response ----------
      mem_resp_valid = 1'b0;
      mem_resp_data  = $urandom;
      mem_resp_err   = 1'($urandom);
      if (outstanding) begin
        cd--;
        if (cd == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = sched_data;
          mem_resp_err   = sched_err;
          outstanding    = 0;
        end
      end else if (stray > 0) begin
        stray--;
        mem_resp_valid = 1'b1;
      end else if (!directed && $urandom_range(0, 6) == 0) begin
        mem_resp_valid = 1'b1;
      end

      // ---------- memory request ----------
      mem_req_ready = directed ? 1'b1 : 1'($urandom_range(0, 1));
      if (mem_req_valid && mem_req_ready && awaiting && !accepted && aligned(exp_addr)) begin
        accepted    = 1;
        accept_iter = it;
        if (directed) begin
          lat = 1; sched_data = 32'h0000_0013; sched_err = 1'b0;
        end else begin
          lat = ($urandom_range(0, 2) != 0) ? $urandom_range(1, 2) : $urandom_range(1, TMO + 2);
          sched_data = $urandom;
          sched_err  = ($urandom_range(0, 7) == 0);
        end
        cd          = lat;
        outstanding = 1;
        have_outcome = 1;
        if (lat <= TMO) begin
          exp_inst     = sched_err ? 32'd0 : sched_data;
          exp_fault    = sched_err;
          exp_out_iter = it + lat + 1;
        end else begin
          exp_inst     = 32'd0;
          exp_fault    = 1'b1;
          exp_out_iter = it + TMO + 1;
        end
      end

      // ---------- decode / execute ----------
      inst_ready = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      npc_valid  = 1'b0;
      npc        = $urandom;
      if (inst_valid && inst_ready && awaiting) begin
        exp_cnt   = exp_cnt + 32'd1;
        awaiting  = 0;
        pending   = 1;
        npc_delay = directed ? 0 : $urandom_range(0, 3);
      end else if (awaiting && !inst_valid && !directed && $urandom_range(0, 4) == 0) begin
        npc_valid = 1'b1;
      end
      if (pending) begin
        if (npc_delay == 0) begin
          logic [31:0] a;
          a         = next_addr();
          npc_valid = 1'b1;
          npc       = a;
          pending   = 0;
          deliver(a, it);
        end else begin
          npc_delay--;
        end
      end
    end

    check("rst_mid_done", 32'(did_rst), 32'd1);
    check("fetches_seen", 32'(n_deliv > 20), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage. Sits directly upstream of instruction decode and execute, and replaces the combinational DPI instruction read.
- Owns the architectural PC and issues one word-fetch request at a time to instruction memory over a valid/ready request channel plus a response channel.
- Presents the fetched instruction and its PC to decode over a valid/ready handshake.
- Waits for the next-PC (dnpc) from execute before starting the next fetch. No prediction; one instruction in flight.

Parameters:
- RESET_PC, 32'h80000000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles in WAIT before the fetch is aborted as a fault; range 1..65535.

Ports:
- clk  input  1  clock, all state on posedge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- mem_req_valid  output  1  fetch request valid.
- mem_req_ready  input  1  memory accepts the request.
- mem_req_addr  output  32  fetch address; always equals pc.
- mem_resp_valid  input  1  response data valid.
- mem_resp_data  input  32  instruction word.
- mem_resp_err  input  1  access error, qualified by mem_resp_valid.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode/execute consumes the instruction.
- inst  output  32  instruction word; 0 when inst_fault=1.
- inst_pc  output  32  PC of inst.
- inst_fault  output  1  fetch fault: misaligned PC, memory error, or timeout.
- npc_valid  input  1  execute delivers the next PC.
- npc  input  32  next PC (dnpc).
- fetch_cnt  output  32  count of instructions handed to decode; wraps at 2^32.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC, all registered fields cleared.
  - mem_req_valid=0, inst_valid=0, inst=0, inst_pc=RESET_PC, inst_fault=0, fetch_cnt=0.
  - Reset asserted mid-operation discards any outstanding request. A late mem_resp_valid arriving after reset is ignored, because it only matters in WAIT.
- States: IDLE, REQ, WAIT, OUT, NPC.
- IDLE: on the first clock after reset release, go to REQ.
- REQ:
  - If pc[1:0]!=0: mem_req_valid stays 0. Next cycle go to OUT with inst=0, inst_fault=1.
  - Otherwise mem_req_valid=1 and mem_req_addr=pc, both held stable until mem_req_ready.
  - On valid&&ready go to WAIT and clear the timeout counter.
- WAIT:
  - mem_req_valid=0. The response is legal no earlier than the cycle after acceptance.
  - On mem_resp_valid: capture inst=mem_resp_err?0:mem_resp_data and inst_fault=mem_resp_err, then go to OUT.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no response, go to OUT with inst=0, inst_fault=1.
  - A response arriving in the same cycle the counter reaches TIMEOUT wins: the data is taken.
- OUT:
  - inst_valid=1. inst, inst_pc, and inst_fault are registered and held stable until inst_ready.
  - On inst_valid&&inst_ready: fetch_cnt+=1 and inst_valid drops the next cycle.
  - If npc_valid is high in the same cycle, pc<=npc and go to REQ. This is the single-cycle execute path, with fetch latency of 2 cycles plus memory latency.
  - Otherwise go to NPC.
- NPC: on npc_valid, pc<=npc and go to REQ.
- npc_valid in IDLE, REQ, WAIT, or in OUT without the handshake is ignored.
- mem_resp_valid outside WAIT is ignored.
- Faults do not stop fetching. Execute decides the trap target and returns it via npc.
- inst_pc always equals the pc used for that fetch. An npc with bit0 set is used as-is; REQ flags it misaligned.
- Minimum loop with zero-wait memory and decode: IDLE→REQ→WAIT→OUT→REQ, one instruction per 3 cycles.

Test Plan:
- Release reset; memory ready=1 with 1-cycle response 0x00000013; inst_ready=1 and npc_valid=1 with npc=0x80000004 at handshake → mem_req_addr=0x80000000 in cycle 1; inst=0x00000013, inst_pc=0x80000000 in cycle 3; next request to 0x80000004; fetch_cnt=1.
- mem_req_ready held 0 for 5 cycles → mem_req_valid=1 and mem_req_addr stable all 5 cycles; exactly one request accepted.
- inst_ready=0 for 4 cycles in OUT, then 1; npc_valid arrives 2 cycles later with 0x80000100 → inst stable and fetch_cnt unchanged during stall; fetch_cnt=1 after handshake; state NPC; next request to 0x80000100.
- npc=0x80000102 → no memory request; OUT with inst_fault=1, inst=0, inst_pc=0x80000102.
- TIMEOUT=4, no response → inst_fault=1 after 4 WAIT cycles. Separate case: mem_resp_err=1 → inst_fault=1, inst=0.
- reset pulsed low during WAIT, then a stray mem_resp_valid arrives → all outputs at reset values immediately; stray response ignored; refetch from 0x80000000.
